// File: rtl/decode_pipe.sv
// WISC decode stage: 8-entry register file, immediate/destination decode,
// load-use stall detection and a valid/ready output register.
module decode_pipe #(
  parameter int DATA_W = 16,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [15:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [2:0]        wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [2:0]        out_wreg,
  output logic              out_wen,
  output logic [15:0]       out_instr,
  output logic [DATA_W-1:0] out_pc
);

  logic [7:0][DATA_W-1:0] rf;
  logic [4:0]             op;
  logic [2:0]             rs_sel, rt_sel;
  logic [DATA_W-1:0]      rs_data, rt_data, imm;
  logic [2:0]             wreg;
  logic                   wen, rs_used, rt_used, stall, accept;

  assign op     = in_instr[15:11];
  assign rs_sel = in_instr[10:8];
  assign rt_sel = in_instr[7:5];

  always_comb begin
    imm     = '0;
    wreg    = rt_sel;
    wen     = 1'b1;
    rs_used = 1'b1;
    rt_used = 1'b0;

    // 0101? must precede 010?? so the logical-immediate ops stay zero-extended
    casez (op)
      5'b0101?:                            imm = {{(DATA_W-5){1'b0}}, in_instr[4:0]};
      5'b010??, 5'b10000, 5'b10001,
      5'b10011:                            imm = {{(DATA_W-5){in_instr[4]}}, in_instr[4:0]};
      5'b10010:                            imm = {{(DATA_W-8){1'b0}}, in_instr[7:0]};
      5'b011??, 5'b11000, 5'b00101,
      5'b00111:                            imm = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
      5'b00100, 5'b00110:                  imm = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};
      default:                             imm = '0;
    endcase

    casez (op)
      5'b11011, 5'b11010, 5'b111??:        wreg = in_instr[4:2];
      5'b11000, 5'b10010, 5'b10011:        wreg = rs_sel;
      5'b00110, 5'b00111:                  wreg = 3'b111;
      default:                             wreg = rt_sel;
    endcase

    casez (op)
      5'b00000, 5'b00001, 5'b00100, 5'b00101,
      5'b011??, 5'b10000:                  wen = 1'b0;
      default:                             wen = 1'b1;
    endcase

    casez (op)
      5'b00000, 5'b00001, 5'b00100, 5'b00110,
      5'b11000:                            rs_used = 1'b0;
      default:                             rs_used = 1'b1;
    endcase

    casez (op)
      5'b1101?, 5'b111??, 5'b10000,
      5'b10011:                            rt_used = 1'b1;
      default:                             rt_used = 1'b0;
    endcase
  end

  assign rs_data = ((BYPASS != 0) && wb_en && (wb_reg == rs_sel)) ? wb_data : rf[rs_sel];
  assign rt_data = ((BYPASS != 0) && wb_en && (wb_reg == rt_sel)) ? wb_data : rf[rt_sel];

  // A load in the output register cannot supply its data to the next op yet.
  assign stall = out_valid && (out_instr[15:11] == 5'b10001) &&
                 ((rs_used && (out_wreg == rs_sel)) || (rt_used && (out_wreg == rt_sel)));

  assign in_ready = !rst && (!out_valid || out_ready) && !stall && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf          <= '0;
      out_valid   <= 1'b0;
      out_rs_data <= '0;
      out_rt_data <= '0;
      out_imm     <= '0;
      out_wreg    <= '0;
      out_wen     <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
    end else begin
      if (wb_en) rf[wb_reg] <= wb_data;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_rs_data <= rs_data;
        out_rt_data <= rt_data;
        out_imm     <= imm;
        out_wreg    <= wreg;
        out_wen     <= wen;
        out_instr   <= in_instr;
        out_pc      <= in_pc;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
